// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM command path.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_DATA,
        RD_ISSUE,
        RD_WAIT,
        RD_SEND,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM, MEM_DEPTH+1 words; registered read one cycle after address with oe.
// No backpressure: a write or read is taken on every enabled cycle.
module single_port_ram #(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = $clog2(MEM_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_oe,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_in_range;

    assign w_in_range = (i_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (i_we && w_in_range) begin
            r_mem[i_addr] <= i_wr_data;
        end
        if (i_oe && w_in_range) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spi_ram_cmd_ctrl.sv
// Frame decoder [CMD][ADDR][DATA...] driving single_port_ram; write lands 1 cycle after last byte,
// read bytes appear 3 cycles after the address byte and are held on tx_data until tx_ready.
module spi_ram_cmd_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = $clog2(MEM_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  frame_end,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  busy,
    output logic                  err
);

    localparam int                BPW       = bytes_per_word(DATA_WIDTH);
    localparam int                CNT_W     = $clog2(BPW + 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [7:0]        MAX_ADDR  = 8'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_is_read;
    logic [ADDR_W-1:0]     r_addr;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [DATA_WIDTH-1:0] r_wr_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;

    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic                  r_ram_we;
    logic                  r_ram_oe;
    logic [DATA_WIDTH-1:0] r_ram_wr_data;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_tx_accept;
    logic                  w_cnt_last;
    logic                  w_cmd_ok;
    logic                  w_addr_ok;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [ADDR_W-1:0]     w_addr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_accept  = r_tx_valid && tx_ready;
        w_cnt_last   = (r_byte_cnt == LAST_BYTE);
        w_cmd_ok     = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
        w_addr_ok    = (rx_data <= MAX_ADDR);
        w_wr_word    = (r_wr_shift << 8) | DATA_WIDTH'(rx_data);
        w_addr_next  = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;

        if (frame_end) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        w_next_state = w_cmd_ok ? ADDR : IGNORE;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        if (!w_addr_ok) begin
                            w_next_state = IGNORE;
                        end else begin
                            w_next_state = r_is_read ? RD_ISSUE : WR_DATA;
                        end
                    end
                end
                RD_ISSUE: w_next_state = RD_WAIT;
                RD_WAIT:  w_next_state = RD_SEND;
                RD_SEND: begin
                    if (w_tx_accept && w_cnt_last) begin
                        w_next_state = RD_ISSUE;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_read     <= 1'b0;
            r_addr        <= '0;
            r_byte_cnt    <= '0;
            r_wr_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_oe      <= 1'b0;
            r_ram_wr_data <= '0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_busy   <= (w_next_state != IDLE);

            // frame_end wins over any byte; a word still in the shift register is dropped
            if (frame_end) begin
                r_tx_valid <= 1'b0;
                r_ram_oe   <= 1'b0;
                r_byte_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (rx_valid) begin
                            r_is_read <= (rx_data == CMD_READ);
                            r_err     <= !w_cmd_ok;
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            if (!w_addr_ok) begin
                                r_err <= 1'b1;
                            end else begin
                                r_addr     <= rx_data[ADDR_W-1:0];
                                r_byte_cnt <= '0;
                                if (r_is_read) begin
                                    r_ram_addr <= rx_data[ADDR_W-1:0];
                                    r_ram_oe   <= 1'b1;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (rx_valid) begin
                            r_wr_shift <= w_wr_word;
                            // counter and address advance here so a byte arriving
                            // during the ram_we cycle starts the next word cleanly
                            if (w_cnt_last) begin
                                r_ram_we      <= 1'b1;
                                r_ram_wr_data <= w_wr_word;
                                r_ram_addr    <= r_addr;
                                r_addr        <= w_addr_next;
                                r_byte_cnt    <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end
                    end
                    RD_WAIT: begin
                        r_ram_oe   <= 1'b0;
                        r_tx_data  <= ram_rd_data[DATA_WIDTH-1 -: 8];
                        r_tx_shift <= ram_rd_data << 8;
                        r_tx_valid <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                    RD_SEND: begin
                        if (w_tx_accept) begin
                            if (w_cnt_last) begin
                                r_tx_valid <= 1'b0;
                                r_addr     <= w_addr_next;
                                r_ram_addr <= w_addr_next;
                                r_ram_oe   <= 1'b1;
                                r_byte_cnt <= '0;
                            end else begin
                                r_tx_data  <= r_tx_shift[DATA_WIDTH-1 -: 8];
                                r_tx_shift <= r_tx_shift << 8;
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_oe      = r_ram_oe;
    assign ram_wr_data = r_ram_wr_data;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule

// File: tb/tb_spi_ram_cmd_ctrl.sv
// Directed bench: frame table plus hand sequences for stall, abort, reset and ram_we-cycle corners.
module tb_spi_ram_cmd_ctrl;

    localparam int MEM_DEPTH  = 8;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_W     = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            rx_data = '0;
    logic                  rx_valid = 1'b0;
    logic                  frame_end = 1'b0;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready = 1'b0;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  ram_we;
    logic                  ram_oe;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  busy;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_cnt   = 0;
    logic [ADDR_W+DATA_WIDTH-1:0] we_q [$];

    always #5 clk = ~clk;

    spi_ram_cmd_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_end  (frame_end),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_oe     (ram_oe),
        .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data),
        .busy       (busy),
        .err        (err)
    );

    single_port_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_we     (ram_we),
        .i_oe     (ram_oe),
        .i_addr   (ram_addr),
        .i_wr_data(ram_wr_data),
        .o_rd_data(ram_rd_data)
    );

    always @(negedge clk) begin
        if (ram_we) we_q.push_back({ram_addr, ram_wr_data});
        if (ram_oe) oe_cnt++;
    end

    typedef struct packed {
        logic [0:5][7:0]  bytes;
        logic [3:0]       nb;
        logic             rd;
        logic [1:0]       n_we;
        logic [0:1][3:0]  we_addr;
        logic [0:1][15:0] we_data;
        logic [2:0]       n_tx;
        logic [0:3][7:0]  tx;
        logic             err;
    } frame_t;

    function automatic frame_t mk(input logic [47:0] b, input int nb, input logic rd,
                                  input int n_we, input logic [7:0] wa, input logic [31:0] wd,
                                  input int n_tx, input logic [31:0] tx, input logic e);
        frame_t f;
        f.bytes   = b;
        f.nb      = 4'(nb);
        f.rd      = rd;
        f.n_we    = 2'(n_we);
        f.we_addr = wa;
        f.we_data = wd;
        f.n_tx    = 3'(n_tx);
        f.tx      = tx;
        f.err     = e;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic take_tx(output logic [7:0] b);
        bit seen = 1'b0;
        b = 8'h00;
        for (int t = 0; t < 32 && !seen; t++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        if (!seen) begin
            check("tx_valid_timeout", 32'(tx_valid), 32'd1);
        end else begin
            b        = tx_data;
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input frame_t f, input string tag);
        int         we_base = we_q.size();
        int         oe_base = oe_cnt;
        logic [7:0] got;
        for (int k = 0; k < int'(f.nb); k++) begin
            if (f.rd && k >= 2) begin
                take_tx(got);
                check($sformatf("%s_tx%0d", tag, k - 2), 32'(got), 32'(f.tx[k-2]));
            end
            send_byte(f.bytes[k]);
        end
        end_frame();
        @(negedge clk);
        check({tag, "_we_count"}, 32'(we_q.size() - we_base), 32'(f.n_we));
        for (int j = 0; j < int'(f.n_we); j++) begin
            if (we_base + j < we_q.size()) begin
                check($sformatf("%s_we%0d_addr", tag, j),
                      32'(we_q[we_base+j][ADDR_W+DATA_WIDTH-1:DATA_WIDTH]), 32'(f.we_addr[j]));
                check($sformatf("%s_we%0d_data", tag, j),
                      32'(we_q[we_base+j][DATA_WIDTH-1:0]), 32'(f.we_data[j]));
            end
        end
        check({tag, "_oe_used"}, 32'(oe_cnt > oe_base), 32'(f.rd));
        check({tag, "_err"}, 32'(err), 32'(f.err));
        check({tag, "_busy_after_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        frame_t     vec [10];
        logic [7:0] b0;
        int         base;

        vec[0] = mk(48'h02_03_AB_CD_12_34, 6, 1'b0, 2, 8'h34, 32'hABCD_1234, 0, 32'h0, 1'b0);
        vec[1] = mk(48'h02_08_11_22_33_44, 6, 1'b0, 2, 8'h80, 32'h1122_3344, 0, 32'h0, 1'b0);
        vec[2] = mk(48'h02_01_5A_A5_00_00, 4, 1'b0, 1, 8'h10, 32'h5AA5_0000, 0, 32'h0, 1'b0);
        vec[3] = mk(48'h02_01_EE_00_00_00, 3, 1'b0, 0, 8'h00, 32'h0,         0, 32'h0, 1'b0);
        vec[4] = mk(48'h03_03_00_00_00_00, 6, 1'b1, 0, 8'h00, 32'h0, 4, 32'hABCD_1234, 1'b0);
        vec[5] = mk(48'h03_08_A5_A5_A5_A5, 6, 1'b1, 0, 8'h00, 32'h0, 4, 32'h1122_3344, 1'b0);
        vec[6] = mk(48'h03_01_FF_FF_00_00, 4, 1'b1, 0, 8'h00, 32'h0, 2, 32'h5AA5_0000, 1'b0);
        vec[7] = mk(48'h55_01_02_03_00_00, 4, 1'b0, 0, 8'h00, 32'h0,         0, 32'h0, 1'b1);
        vec[8] = mk(48'h02_0F_AA_BB_00_00, 4, 1'b0, 0, 8'h00, 32'h0,         0, 32'h0, 1'b1);
        vec[9] = mk(48'h02_05_C0_DE_00_00, 4, 1'b0, 1, 8'h50, 32'hC0DE_0000, 0, 32'h0, 1'b0);

        // reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("rst_ram", {11'd0, ram_we, ram_oe, ram_addr, ram_wr_data}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_frame(vec[i], $sformatf("vec%0d", i));
        end

        // tx_ready stalled for 5 cycles: byte must hold
        send_byte(8'h03);
        send_byte(8'h03);
        check("stall_busy", 32'(busy), 32'd1);
        take_tx(b0);
        check("stall_b0", 32'(b0), 32'hAB);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", s), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hCD});
        end
        take_tx(b0);
        check("stall_b1", 32'(b0), 32'hCD);
        end_frame();

        // reset in the middle of a write word
        base = we_q.size();
        send_byte(8'h02);
        send_byte(8'h06);
        send_byte(8'h77);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        end_frame();
        check("rst_mid_no_we", 32'(we_q.size() - base), 32'd0);

        // frame_end coincides with the last data byte
        base = we_q.size();
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h99);
        @(posedge clk); #1;
        rx_data   = 8'hAA;
        rx_valid  = 1'b1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fe_last_no_we", 32'(we_q.size() - base), 32'd0);
        check("fe_last_busy", 32'(busy), 32'd0);

        // frame_end during the ram_we cycle: the write still lands
        base = we_q.size();
        send_byte(8'h02);
        send_byte(8'h06);
        send_byte(8'hDE);
        @(posedge clk); #1;
        rx_data  = 8'hAD;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fe_we_count", 32'(we_q.size() - base), 32'd1);
        if (we_q.size() > base) check("fe_we_word", 32'(we_q[base]), {12'd0, 4'd6, 16'hDEAD});

        // next byte arrives in the ram_we cycle itself
        base = we_q.size();
        send_byte(8'h02);
        send_byte(8'h07);
        send_byte(8'h01);
        @(posedge clk); #1;
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_data  = 8'h03;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        send_byte(8'h04);
        end_frame();
        check("b2b_we_count", 32'(we_q.size() - base), 32'd2);
        if (we_q.size() > base + 1) begin
            check("b2b_we0", 32'(we_q[base]),   {12'd0, 4'd7, 16'h0102});
            check("b2b_we1", 32'(we_q[base+1]), {12'd0, 4'd8, 16'h0304});
        end

        // sticky err cleared by the next good command byte
        send_byte(8'h55);
        end_frame();
        check("err_sticky", 32'(err), 32'd1);
        send_byte(8'h02);
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        end_frame();

        run_frame(mk(48'h03_06_00_00_00_00, 6, 1'b1, 0, 8'h00, 32'h0, 4, 32'hDEAD_0102, 1'b0),
                  "readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
